clock_display: RTL and testbench

CLOCK_DISPLAY -- requirements
Module: clock_display

---
 rtl/clock_display.sv | 142 ++++++++++++++
 tb/tb_clock_display.sv | 137 +++++++++++++
 2 files changed

// File: rtl/clock_display.sv
// Six-digit multiplexed HH:MM:SS seven-segment driver with per-field blink.
// One coherent time snapshot per scan frame; all outputs registered.
module clock_display #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLINK_DIV = 250000
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [4:0] i_hr,
  input  logic [2:0] i_blink,
  output logic [6:0] o_seg,
  output logic       o_dp,
  output logic [5:0] o_digit_en
);

  logic [15:0] presc_q, presc_d;
  logic [2:0]  idx_q, idx_d;
  logic [5:0]  sec_q, sec_d;
  logic [5:0]  min_q, min_d;
  logic [4:0]  hr_q, hr_d;
  logic [23:0] blink_cnt_q, blink_cnt_d;
  logic        blink_ph_q, blink_ph_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [5:0]  digit_en_q, digit_en_d;

  logic        scan_tick;
  logic [5:0]  fld_val;
  logic        fld_oor;
  logic        fld_blk;
  logic [3:0]  digit;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  assign scan_tick = (presc_q == 16'(SCAN_DIV - 1));

  always_comb begin
    presc_d     = scan_tick ? 16'd0 : presc_q + 16'd1;
    idx_d       = idx_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hr_d        = hr_q;
    blink_cnt_d = blink_cnt_q + 24'd1;
    blink_ph_d  = blink_ph_q;

    if (scan_tick) begin
      if (idx_q == 3'd5) begin
        idx_d = 3'd0;
        // Frame boundary: capture all three fields together so a frame never tears.
        sec_d = i_sec;
        min_d = i_min;
        hr_d  = i_hr;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end

    if (blink_cnt_q == 24'(BLINK_DIV - 1)) begin
      blink_cnt_d = 24'd0;
      blink_ph_d  = ~blink_ph_q;
    end
  end

  always_comb begin
    fld_val = sec_q;
    fld_oor = 1'b0;
    fld_blk = 1'b0;
    case (idx_q)
      3'd0, 3'd1: begin
        fld_val = sec_q;
        fld_oor = (sec_q > 6'd59);
        fld_blk = i_blink[0];
      end
      3'd2, 3'd3: begin
        fld_val = min_q;
        fld_oor = (min_q > 6'd59);
        fld_blk = i_blink[1];
      end
      3'd4, 3'd5: begin
        fld_val = {1'b0, hr_q};
        fld_oor = (hr_q > 5'd23);
        fld_blk = i_blink[2];
      end
      default: ;
    endcase

    digit = idx_q[0] ? 4'(fld_val / 6'd10) : 4'(fld_val % 6'd10);
    seg_d = fld_oor ? 7'h40 : seg_of(digit);
    // Blank wins over the out-of-range dash; the digit strobe keeps scanning.
    if (fld_blk && !blink_ph_q) seg_d = 7'h00;

    dp_d       = (idx_q == 3'd2) || (idx_q == 3'd4);
    digit_en_d = 6'b000001 << idx_q;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      presc_q     <= '0;
      idx_q       <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hr_q        <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b1;
      seg_q       <= '0;
      dp_q        <= 1'b0;
      digit_en_q  <= '0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hr_q        <= hr_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      digit_en_q  <= digit_en_d;
    end
  end

  assign o_seg      = seg_q;
  assign o_dp       = dp_q;
  assign o_digit_en = digit_en_q;

endmodule

// File: tb/tb_clock_display.sv
// Bench for clock_display: a cycle-count reference model predicts each output word,
// pushes it to a scoreboard queue, and the word is popped and compared after the edge.
module tb_clock_display;
  localparam int SD = 4;
  localparam int BD = 8;
  localparam int FR = 6 * SD;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [5:0] en;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [5:0] sec = '0;
  logic [5:0] min = '0;
  logic [4:0] hr = '0;
  logic [2:0] blink = '0;
  logic [6:0] o_seg;
  logic       o_dp;
  logic [5:0] o_digit_en;

  int   n_chk = 0;
  int   n_bad = 0;
  int   t = 0;
  int   s_sec = 0, s_min = 0, s_hr = 0;
  exp_t sb_q[$];
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  clock_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_sec(sec), .i_min(min), .i_hr(hr),
    .i_blink(blink), .o_seg(o_seg), .o_dp(o_dp), .o_digit_en(o_digit_en)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   idx, v, lim;
    logic ph, b;
    idx = (t / SD) % 6;
    ph  = (((t / BD) % 2) == 0);
    case (idx / 2)
      0:       begin v = s_sec; lim = 59; b = blink[0]; end
      1:       begin v = s_min; lim = 59; b = blink[1]; end
      default: begin v = s_hr;  lim = 23; b = blink[2]; end
    endcase
    if (v > lim) e.seg = 7'h40;
    else         e.seg = seg_tab[(idx % 2 == 1) ? v / 10 : v % 10];
    if (b && !ph) e.seg = 7'h00;
    e.dp = (idx == 2) || (idx == 4);
    e.en = 6'(1 << idx);
    return e;
  endfunction

  task automatic step();
    exp_t e;
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_val("seg", 32'(o_seg), 32'(e.seg));
    check_val("dp", 32'(o_dp), 32'(e.dp));
    check_val("digit_en", 32'(o_digit_en), 32'(e.en));
    check_val("onehot", 32'($onehot(o_digit_en)), 32'd1);
    if (t % FR == FR - 1) begin
      s_sec = int'(sec);
      s_min = int'(min);
      s_hr  = int'(hr);
    end
    t++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic reset_and_release();
    rstn = 1'b0;
    #1;
    check_val("rst_seg", 32'(o_seg), 32'd0);
    check_val("rst_dp", 32'(o_dp), 32'd0);
    check_val("rst_en", 32'(o_digit_en), 32'd0);
    repeat (2) @(negedge clk);
    rstn  = 1'b1;
    t     = 0;
    s_sec = 0;
    s_min = 0;
    s_hr  = 0;
  endtask

  initial begin
    sec = 6'd56; min = 6'd34; hr = 5'd12; blink = 3'b000;
    #2;
    reset_and_release();
    // Frame 0 shows 00:00:00, frame 1 shows 12:34:56.
    run(2 * FR + 4);

    // Seconds change during index 0 must wait for the next frame.
    sec = 6'd10; min = 6'd0; hr = 5'd0;
    run(FR);
    while (t % FR != 2) step();
    sec = 6'd11;
    run(2 * FR);

    sec = 6'd59; min = 6'd60; hr = 5'd24;
    run(2 * FR);

    sec = 6'd56; min = 6'd34; hr = 5'd12;
    blink = 3'b100;
    run(4 * FR);
    // Blanking overrides the dash.
    min = 6'd61; blink = 3'b011;
    run(2 * FR);
    blink = 3'b000; min = 6'd34;
    run(FR);

    // Asynchronous reset in the middle of index 3.
    while (!(((t / SD) % 6 == 3) && (t % SD == 1))) step();
    #2;
    reset_and_release();
    run(2 * FR);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
